// File: rtl/neg_seq.sv
// neg_seq: streams COUNT elements from a source region of a dual-port buffer
// RAM through a registered two's-complement negator and writes the results to a
// destination region. One read per cycle; a valid tag rides alongside the data
// through the RAM latency plus the negator stage to time the matching write.

// Single negation lane: registers -din whenever a tagged element is present.
module neg_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Hold the last result between elements so wr_data only moves with real data.
   always_ff @(posedge clk) begin
      if (reset)   dout <= '0;
      else if (en) dout <= '0 - din;
   end

endmodule

module neg_seq #(
   parameter int ADDRWIDTH = 10,
   parameter int RD_LAT    = 1,
   parameter int WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDRWIDTH-1:0] src_base,
   input  logic [ADDRWIDTH-1:0] dst_base,
   input  logic [ADDRWIDTH:0]   count,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en,
   output logic [ADDRWIDTH-1:0] rd_addr,
   input  logic [WIDTH-1:0]     rd_data,
   output logic                 wr_en,
   output logic [ADDRWIDTH-1:0] wr_addr,
   output logic [WIDTH-1:0]     wr_data
);

   // RAM latency stages plus the negator register.
   localparam int STAGES = RD_LAT + 1;
   localparam logic [ADDRWIDTH-1:0] A_ONE = 1;
   localparam logic [ADDRWIDTH:0]   C_ONE = 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t             state;
   logic [ADDRWIDTH:0] remain;     // reads still to issue after the current one
   logic [STAGES:1]    vld_q;
   logic [STAGES:0]    vld_pipe;   // [0] = read issued this cycle, [STAGES] = write
   logic               accept;
   logic               last_wr;

   // A zero-length command only pulses done; it never enters READ.
   assign accept   = (state == IDLE) && start && (count != '0);
   assign vld_pipe = {vld_q, rd_en};
   assign wr_en    = vld_pipe[STAGES];
   // The write leaving the pipe is the final one when nothing trails it.
   assign last_wr  = wr_en && (vld_pipe[STAGES-1:0] == '0);

   // Command FSM: issues reads, then waits for the tag pipe to drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         remain  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  busy    <= 1'b1;
                  rd_en   <= 1'b1;
                  rd_addr <= src_base;
                  remain  <= count - C_ONE;
                  state   <= READ;
               end else if (start) begin
                  done <= 1'b1;
               end
            end
            READ: begin
               if (remain == '0) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  rd_addr <= rd_addr + A_ONE;
                  remain  <= remain - C_ONE;
               end
            end
            DRAIN: begin
               if (last_wr) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Valid tag shift register; reset drops every in-flight element.
   always_ff @(posedge clk) begin
      if (reset) vld_q <= '0;
      else       vld_q <= vld_pipe[STAGES-1:0];
   end

   // Destination pointer: loaded on accept, advances after each write.
   always_ff @(posedge clk) begin
      if (reset)       wr_addr <= '0;
      else if (accept) wr_addr <= dst_base;
      else if (wr_en)  wr_addr <= wr_addr + A_ONE;
   end

   neg_unit #(.WIDTH(WIDTH)) u_neg (
      .clk   (clk),
      .reset (reset),
      .en    (vld_pipe[RD_LAT]),
      .din   (rd_data),
      .dout  (wr_data)
   );

endmodule
